// File: rtl/dsi_colorbar_feeder.sv
// Colour-bar frame source feeding the DSI lane FIFOs and the per-line VS/HS/DE control FIFO.
// Optional completed-frame counter output enabled by defining DSI_FEED_FRAME_CNT_EN.
module dsi_colorbar_feeder #(
    parameter int H_ACTIVE = 1080,
    parameter int V_ACTIVE = 1920,
    parameter int V_BLANK  = 20
) (
    input  logic        I_lcd_clk,
    input  logic        I_rst,
    input  logic        I_en,
    input  logic        I_full_lane0,
    input  logic        I_full_lane1,
    input  logic        I_full_lane2,
    input  logic        I_full_lane3,
    output logic        O_lane0_wren,
    output logic        O_lane1_wren,
    output logic        O_lane2_wren,
    output logic        O_lane3_wren,
    output logic [15:0] O_lane0_data,
    output logic [15:0] O_lane1_data,
    output logic [15:0] O_lane2_data,
    output logic [15:0] O_lane3_data,
    input  logic        I_full_vshsde,
    output logic        O_vshsde_wren,
    output logic [7:0]  O_vshsde_data
`ifdef DSI_FEED_FRAME_CNT_EN
    ,output logic [15:0] O_frame_cnt
`endif
);

    localparam logic [15:0] BAR_W_C   = 16'(H_ACTIVE / 8);
    localparam logic [15:0] LAST_BEAT = 16'((3 * H_ACTIVE / 8) - 1);
    localparam logic [15:0] LAST_LINE = 16'(V_BLANK + V_ACTIVE - 1);
    localparam logic [15:0] DE_FIRST  = 16'(V_BLANK);

    typedef enum logic [1:0] {S_IDLE, S_CTRL, S_DATA, S_NEXT} state_t;

    state_t      state_q, state_d;
    logic [15:0] line_q, line_d;
    logic [15:0] beat_q, beat_d;
    logic [15:0] pos_q, pos_d;
    logic [1:0]  phase_q, phase_d;
    logic [2:0]  bar_q, bar_d;
`ifdef DSI_FEED_FRAME_CNT_EN
    logic [15:0] frame_q, frame_d;
`endif

    logic        lane_wren, ctrl_wren, de, vs;
    logic [7:0]  ctrl_byte;
    logic [7:0]  beat_bytes [8];
    logic [1:0]  pix_adv, phase_nxt;
    logic [15:0] pos_sum;

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    endfunction

    // Byte j of the beat: pixel offset and colour component follow from the phase of byte 0;
    // the bar can only advance by one within a beat since a bar is at least 3 pixels wide.
    function automatic logic [7:0] beat_byte(input logic [3:0] j, input logic [1:0] ph,
                                             input logic [15:0] pos, input logic [2:0] bar);
        logic [3:0]  tot;
        logic [1:0]  off;
        logic [1:0]  comp;
        logic [2:0]  idx;
        logic [23:0] rgb;
        tot  = {2'b00, ph} + j;
        off  = 2'(tot / 4'd3);
        comp = 2'(tot % 4'd3);
        idx  = ((pos + {14'b0, off}) >= BAR_W_C) ? bar + 3'd1 : bar;
        rgb  = bar_rgb(idx);
        case (comp)
            2'd0:    beat_byte = rgb[23:16];
            2'd1:    beat_byte = rgb[15:8];
            default: beat_byte = rgb[7:0];
        endcase
    endfunction

    always_comb begin
        for (int j = 0; j < 8; j++) begin
            beat_bytes[j] = beat_byte(4'(j), phase_q, pos_q, bar_q);
        end
    end

    assign lane_wren = (state_q == S_DATA) &&
                       !(I_full_lane0 || I_full_lane1 || I_full_lane2 || I_full_lane3);
    assign ctrl_wren = (state_q == S_CTRL) && !I_full_vshsde;
    assign vs        = (line_q == 16'd0);
    assign de        = (line_q >= DE_FIRST) && (line_q <= LAST_LINE);
    assign ctrl_byte = {5'b00000, vs, 1'b1, de};

    assign O_vshsde_wren = ctrl_wren;
    assign O_vshsde_data = ctrl_wren ? ctrl_byte : 8'h00;
    assign O_lane0_wren  = lane_wren;
    assign O_lane1_wren  = lane_wren;
    assign O_lane2_wren  = lane_wren;
    assign O_lane3_wren  = lane_wren;
    assign O_lane0_data  = lane_wren ? {beat_bytes[4], beat_bytes[0]} : 16'h0000;
    assign O_lane1_data  = lane_wren ? {beat_bytes[5], beat_bytes[1]} : 16'h0000;
    assign O_lane2_data  = lane_wren ? {beat_bytes[6], beat_bytes[2]} : 16'h0000;
    assign O_lane3_data  = lane_wren ? {beat_bytes[7], beat_bytes[3]} : 16'h0000;
`ifdef DSI_FEED_FRAME_CNT_EN
    assign O_frame_cnt   = frame_q;
`endif

    // 8 bytes per beat advance the byte phase by 2 (mod 3) and the pixel by 2 or 3.
    always_comb begin
        case (phase_q)
            2'd0:    begin pix_adv = 2'd2; phase_nxt = 2'd2; end
            2'd1:    begin pix_adv = 2'd3; phase_nxt = 2'd0; end
            default: begin pix_adv = 2'd3; phase_nxt = 2'd1; end
        endcase
        pos_sum = pos_q + {14'b0, pix_adv};
    end

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        beat_d  = beat_q;
        pos_d   = pos_q;
        phase_d = phase_q;
        bar_d   = bar_q;
`ifdef DSI_FEED_FRAME_CNT_EN
        frame_d = frame_q;
`endif
        case (state_q)
            S_IDLE: begin
                line_d = 16'd0;
                if (I_en) state_d = S_CTRL;
            end
            S_CTRL: begin
                if (ctrl_wren) state_d = de ? S_DATA : S_NEXT;
            end
            S_DATA: begin
                if (lane_wren) begin
                    beat_d  = beat_q + 16'd1;
                    phase_d = phase_nxt;
                    if (pos_sum >= BAR_W_C) begin
                        pos_d = pos_sum - BAR_W_C;
                        bar_d = bar_q + 3'd1;
                    end else begin
                        pos_d = pos_sum;
                    end
                    if (beat_q == LAST_BEAT) state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                beat_d  = 16'd0;
                pos_d   = 16'd0;
                phase_d = 2'd0;
                bar_d   = 3'd0;
                if (line_q == LAST_LINE) begin
                    line_d  = 16'd0;
                    state_d = I_en ? S_CTRL : S_IDLE;
`ifdef DSI_FEED_FRAME_CNT_EN
                    frame_d = frame_q + 16'd1;
`endif
                end else begin
                    line_d  = line_q + 16'd1;
                    state_d = S_CTRL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_lcd_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= S_IDLE;
            line_q  <= 16'd0;
            beat_q  <= 16'd0;
            pos_q   <= 16'd0;
            phase_q <= 2'd0;
            bar_q   <= 3'd0;
`ifdef DSI_FEED_FRAME_CNT_EN
            frame_q <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            beat_q  <= beat_d;
            pos_q   <= pos_d;
            phase_q <= phase_d;
            bar_q   <= bar_d;
`ifdef DSI_FEED_FRAME_CNT_EN
            frame_q <= frame_d;
`endif
        end
    end

endmodule
